led_pattern_engine: RTL and testbench

- Parametrised successor to the board's single-pattern LED scroller: drives LED_COUNT LEDs with a selectable pattern, advanced by an internal prescaler.
- Adds run-time mode select, enable/pause, configurable polarity, a step strobe and a position output for other board logic.
- Sits directly on the board LED pins, clocked from the 27 MHz system clock.

---
 rtl/led_pattern_engine.sv | 156 +++++++++++++++
 tb/tb_led_pattern_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// Multi-mode LED pattern engine: bounce, rotate up/down and bar-graph bounce, stepped by a prescaler.
// Optional PWM brightness control is compiled in with LED_PATTERN_BRIGHTNESS_EN.
module led_pattern_engine #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int LED_COUNT       = 6,
  parameter int STEP_DELAY      = 1000,
  parameter int ACTIVE_LOW      = 1,
  localparam int POS_W          = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
`ifdef LED_PATTERN_BRIGHTNESS_EN
  input  logic [3:0]           brightness,
`endif
  output logic [LED_COUNT-1:0] leds,
  output logic                 step,
  output logic [POS_W-1:0]     position
);

  localparam int PRESC_W = (STEP_DELAY > 1) ? $clog2(STEP_DELAY) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DELAY - 1);
  localparam logic [PRESC_W-1:0] PRESC_INC  = PRESC_W'(1);
  localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(LED_COUNT - 1);
  localparam logic [POS_W-1:0]   POS_PENULT = POS_W'((LED_COUNT > 1) ? LED_COUNT - 2 : 0);
  localparam logic [POS_W-1:0]   POS_ONE    = POS_W'((LED_COUNT > 1) ? 1 : 0);
  localparam logic [POS_W-1:0]   POS_INC    = POS_W'(1);

  if (LED_COUNT < 1 || LED_COUNT > 32) begin : g_bad_led_count
    $error("LED_COUNT must be in 1..32");
  end
  if (STEP_DELAY < 1 || STEP_DELAY > (1 << 24)) begin : g_bad_step_delay
    $error("STEP_DELAY must be in 1..2^24");
  end
  if (CLOCK_FREQUENCY < 1) begin : g_bad_clock_frequency
    $error("CLOCK_FREQUENCY must be positive");
  end

  typedef enum logic [1:0] {
    MODE_BOUNCE   = 2'd0,
    MODE_ROT_UP   = 2'd1,
    MODE_ROT_DOWN = 2'd2,
    MODE_BAR      = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  logic [POS_W-1:0]   pos_reg,    pos_next,   pos_step;
  dir_t               dir_reg,    dir_next,   dir_step;
  logic [PRESC_W-1:0] presc_reg,  presc_next;
  mode_t              mode_q_reg, mode_q_next;
  logic               step_reg,   step_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_reg    <= '0;
      dir_reg    <= DIR_UP;
      presc_reg  <= '0;
      mode_q_reg <= mode_t'(mode);
      step_reg   <= 1'b0;
    end else begin
      pos_reg    <= pos_next;
      dir_reg    <= dir_next;
      presc_reg  <= presc_next;
      mode_q_reg <= mode_q_next;
      step_reg   <= step_next;
    end
  end

  // Candidate position/direction if a step were taken this cycle.
  always_comb begin
    pos_step = pos_reg;
    dir_step = dir_reg;
    case (mode_q_reg)
      MODE_ROT_UP:   pos_step = (pos_reg == POS_LAST) ? '0 : pos_reg + POS_INC;
      MODE_ROT_DOWN: pos_step = (pos_reg == '0) ? POS_LAST : pos_reg - POS_INC;
      default: begin
        if (dir_reg == DIR_UP) begin
          if (pos_reg == POS_LAST) begin
            dir_step = DIR_DOWN;
            pos_step = POS_PENULT;
          end else begin
            pos_step = pos_reg + POS_INC;
          end
        end else if (pos_reg == '0) begin
          dir_step = DIR_UP;
          pos_step = POS_ONE;
        end else begin
          pos_step = pos_reg - POS_INC;
        end
      end
    endcase
    // A single LED has nowhere to move; keep the direction pinned upward.
    if (LED_COUNT == 1) begin
      pos_step = '0;
      dir_step = DIR_UP;
    end
  end

  always_comb begin
    pos_next    = pos_reg;
    dir_next    = dir_reg;
    presc_next  = presc_reg;
    mode_q_next = mode_q_reg;
    step_next   = 1'b0;
    if (mode_t'(mode) != mode_q_reg) begin
      // Mode change restarts the pattern and overrides a coincident step.
      mode_q_next = mode_t'(mode);
      pos_next    = '0;
      dir_next    = DIR_UP;
      presc_next  = '0;
    end else if (enable) begin
      if (presc_reg == PRESC_LAST) begin
        presc_next = '0;
        step_next  = 1'b1;
        pos_next   = pos_step;
        dir_next   = dir_step;
      end else begin
        presc_next = presc_reg + PRESC_INC;
      end
    end
  end

  logic [LED_COUNT-1:0] pattern;
  logic [LED_COUNT-1:0] lit;

  for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_pattern
    localparam logic [POS_W-1:0] IDX = POS_W'(gi);
    assign pattern[gi] = (mode_q_reg == MODE_BAR) ? (IDX <= pos_reg) : (IDX == pos_reg);
  end

`ifdef LED_PATTERN_BRIGHTNESS_EN
  logic [3:0] pwm_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_cnt_reg <= 4'd0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 4'd1;
    end
  end

  assign lit = pattern & {LED_COUNT{pwm_cnt_reg < brightness}};
`else
  assign lit = pattern;
`endif

  assign leds     = (ACTIVE_LOW != 0) ? ~lit : lit;
  assign step     = step_reg;
  assign position = pos_reg;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine: a main 6-LED instance plus 1-LED and 2-LED edge instances.
module tb_led_pattern_engine;

  logic       clk = 1'b0;
  logic       rst_a, rst_bc, enable;
  logic [1:0] mode;

  logic [5:0] leds_a;
  logic       step_a;
  logic [2:0] pos_a;
  logic [0:0] leds_b;
  logic       step_b;
  logic [0:0] pos_b;
  logic [1:0] leds_c;
  logic       step_c;
  logic [0:0] pos_c;

`ifdef LED_PATTERN_BRIGHTNESS_EN
  logic [3:0] bright;
  logic [3:0] pwm_a, pwm_bc;
`endif

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  int bounce_exp [20] = '{2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};

  always #5 clk = ~clk;

  led_pattern_engine #(.LED_COUNT(6), .STEP_DELAY(4), .ACTIVE_LOW(1)) dut_a (
    .clock(clk), .reset(rst_a), .enable(enable), .mode(mode),
`ifdef LED_PATTERN_BRIGHTNESS_EN
    .brightness(bright),
`endif
    .leds(leds_a), .step(step_a), .position(pos_a)
  );

  led_pattern_engine #(.LED_COUNT(1), .STEP_DELAY(4), .ACTIVE_LOW(1)) dut_b (
    .clock(clk), .reset(rst_bc), .enable(enable), .mode(mode),
`ifdef LED_PATTERN_BRIGHTNESS_EN
    .brightness(bright),
`endif
    .leds(leds_b), .step(step_b), .position(pos_b)
  );

  led_pattern_engine #(.LED_COUNT(2), .STEP_DELAY(1), .ACTIVE_LOW(0)) dut_c (
    .clock(clk), .reset(rst_bc), .enable(enable), .mode(mode),
`ifdef LED_PATTERN_BRIGHTNESS_EN
    .brightness(bright),
`endif
    .leds(leds_c), .step(step_c), .position(pos_c)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
`ifdef LED_PATTERN_BRIGHTNESS_EN
      pwm_a  = rst_a  ? 4'd0 : pwm_a + 4'd1;
      pwm_bc = rst_bc ? 4'd0 : pwm_bc + 4'd1;
`endif
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pin levels of the active-low 6-LED instance for a given lit pattern.
  function automatic logic [5:0] pins_a(input logic [5:0] lit);
`ifdef LED_PATTERN_BRIGHTNESS_EN
    if (!(pwm_a < bright)) return 6'h3f;
`endif
    return ~lit;
  endfunction

  function automatic logic [1:0] pins_bc(input logic [1:0] lit, input int n, input bit al);
    logic [1:0] mask;
    logic [1:0] l;
    mask = (n == 1) ? 2'b01 : 2'b11;
    l = lit;
`ifdef LED_PATTERN_BRIGHTNESS_EN
    if (!(pwm_bc < bright)) l = 2'b00;
`endif
    return al ? (~l & mask) : l;
  endfunction

  initial begin
    logic [2:0] p;
    int active;

    rst_a  = 1'b1;
    rst_bc = 1'b1;
    enable = 1'b1;
    mode   = 2'd0;
`ifdef LED_PATTERN_BRIGHTNESS_EN
    bright = 4'd15;
    pwm_a  = 4'd0;
    pwm_bc = 4'd0;
`endif
    tick(3);
    check("rst_pos", 32'(pos_a), 0);
    check("rst_leds", 32'(leds_a), 32'(pins_a(6'b000001)));
    check("rst_step", 32'(step_a), 0);

    // First step after release lands exactly STEP_DELAY cycles later.
    rst_a = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("pre_step", 32'(step_a), 0);
      check("pre_pos", 32'(pos_a), 0);
    end
    tick();
    check("first_step", 32'(step_a), 1);
    check("first_pos", 32'(pos_a), 1);
    check("first_leds", 32'(leds_a), 32'(pins_a(6'b000010)));

    for (int i = 0; i < 20; i++) begin
      tick(3);
      check("bounce_gap", 32'(step_a), 0);
      tick();
      check("bounce_step", 32'(step_a), 1);
      check("bounce_pos", 32'(pos_a), 32'(bounce_exp[i]));
    end

    mode = 2'd1;
    tick();
    check("mode1_pos", 32'(pos_a), 0);
    check("mode1_step", 32'(step_a), 0);
    tick(20);
    check("rot_up_top", 32'(pos_a), 5);
    check("rot_up_leds", 32'(leds_a), 32'(pins_a(6'b100000)));
    tick(4);
    check("rot_up_wrap", 32'(pos_a), 0);
    check("rot_up_step", 32'(step_a), 1);

    mode = 2'd2;
    tick();
    check("mode2_pos", 32'(pos_a), 0);
    check("mode2_step", 32'(step_a), 0);
    tick(4);
    check("rot_dn_wrap", 32'(pos_a), 5);
    check("rot_dn_step", 32'(step_a), 1);
    check("rot_dn_leds", 32'(leds_a), 32'(pins_a(6'b100000)));
    tick(4);
    check("rot_dn_next", 32'(pos_a), 4);

    mode = 2'd3;
    tick();
    check("mode3_pos", 32'(pos_a), 0);
    check("mode3_step", 32'(step_a), 0);
    check("bar_leds0", 32'(leds_a), 32'(pins_a(6'b000001)));
    tick(8);
    check("bar_pos2", 32'(pos_a), 2);
    check("bar_leds2", 32'(leds_a), 32'(pins_a(6'b000111)));

    // Pause with the prescaler at 2; two enabled cycles remain to the next step.
    tick(2);
    check("pre_pause_step", 32'(step_a), 0);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("pause_pos", 32'(pos_a), 2);
      check("pause_step", 32'(step_a), 0);
      check("pause_leds", 32'(leds_a), 32'(pins_a(6'b000111)));
    end
    enable = 1'b1;
    tick();
    check("resume1_step", 32'(step_a), 0);
    check("resume1_pos", 32'(pos_a), 2);
    tick();
    check("resume2_step", 32'(step_a), 1);
    check("resume2_pos", 32'(pos_a), 3);
    check("resume2_leds", 32'(leds_a), 32'(pins_a(6'b001111)));

    // Mode change on the terminal-count cycle suppresses the step.
    tick(3);
    check("tc_pre_pos", 32'(pos_a), 3);
    mode = 2'd0;
    tick();
    check("tc_mode_pos", 32'(pos_a), 0);
    check("tc_mode_step", 32'(step_a), 0);

    tick(24);
    check("mid_bounce_pos", 32'(pos_a), 4);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("mid_rst_pos", 32'(pos_a), 0);
    check("mid_rst_step", 32'(step_a), 0);
    check("mid_rst_leds", 32'(leds_a), 32'(pins_a(6'b000001)));
    tick(4);
    check("post_rst_pos", 32'(pos_a), 1);

    rst_bc = 1'b0;
    check("b_rst_pos", 32'(pos_b), 0);
    check("b_rst_step", 32'(step_b), 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("b_step", 32'(step_b), (k % 4 == 0) ? 1 : 0);
      check("b_pos", 32'(pos_b), 0);
      check("b_leds", 32'(leds_b), 32'(pins_bc(2'b01, 1, 1'b1)));
      check("c_pos", 32'(pos_c), 32'(k % 2));
      check("c_step", 32'(step_c), 1);
      check("c_leds", 32'(leds_c), 32'(pins_bc((k % 2 == 1) ? 2'b10 : 2'b01, 2, 1'b0)));
    end

`ifdef LED_PATTERN_BRIGHTNESS_EN
    enable = 1'b0;
    bright = 4'd4;
    tick();
    p = pos_a;
    active = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (leds_a[p] == 1'b0) active++;
    end
    check("bright4_active", 32'(active), 4);
    bright = 4'd0;
    tick();
    check("bright0_leds", 32'(leds_a), 32'h3f);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
